// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired sequencer: opcodes, step encodings, IR fields, strobe bundle.
// Pure declarations; no timing or flow control.
package control_unit_pkg;

  localparam int OPW   = 5;
  localparam int STEPW = 4;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_HI  = 18;
  localparam int C_LO  = 0;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [STEPW-1:0] {
    T0     = 4'd0,
    T1     = 4'd1,
    T2     = 4'd2,
    T3     = 4'd3,
    T4     = 4'd4,
    T5     = 4'd5,
    T6     = 4'd6,
    T7     = 4'd7,
    RST_S  = 4'd8,
    HALT_S = 4'd9
  } step_e;

  localparam int CL_ALU_R  = 0;
  localparam int CL_ALU_I  = 1;
  localparam int CL_MULDIV = 2;
  localparam int CL_UNARY  = 3;
  localparam int CL_LD     = 4;
  localparam int CL_LDI    = 5;
  localparam int CL_ST     = 6;
  localparam int CL_BR     = 7;
  localparam int CL_JR     = 8;
  localparam int CL_JAL    = 9;
  localparam int CL_IO     = 10;
  localparam int CL_MFX    = 11;
  localparam int CL_NOP    = 12;
  localparam int CL_HALT   = 13;
  localparam int NCLS      = 14;

  localparam int A_AND  = 0;
  localparam int A_OR   = 1;
  localparam int A_ADD  = 2;
  localparam int A_SUB  = 3;
  localparam int A_MUL  = 4;
  localparam int A_DIV  = 5;
  localparam int A_SHR  = 6;
  localparam int A_SHRA = 7;
  localparam int A_SHL  = 8;
  localparam int A_ROR  = 9;
  localparam int A_ROL  = 10;
  localparam int A_NEG  = 11;
  localparam int A_NOT  = 12;
  localparam int NALU   = 13;

  typedef struct packed {
    logic            run;
    logic            CON_RESET;
    logic            HIout;
    logic            LOout;
    logic            Zhighout;
    logic            Zlowout;
    logic            PCout;
    logic            MDRout;
    logic            INout;
    logic            Cout;
    logic            Gra;
    logic            Grb;
    logic            Grc;
    logic            Rin;
    logic            Rout;
    logic            BAout;
    logic            HIin;
    logic            LOin;
    logic            PCin;
    logic            IRin;
    logic            Zin;
    logic            Yin;
    logic            MARin;
    logic            MDRin;
    logic            CONin;
    logic            OUT_Portin;
    logic            Read;
    logic            Write;
    logic            IncPC;
    logic [NALU-1:0] alu;
  } ctl_t;

  // Final step of each instruction class; anything unrecognised ends at T2 like a nop.
  function automatic step_e last_step(input logic [NCLS-1:0] cls);
    step_e s;
    s = T2;
    if (cls[CL_JR] | cls[CL_IO] | cls[CL_MFX])          s = T3;
    if (cls[CL_UNARY] | cls[CL_JAL])                    s = T4;
    if (cls[CL_ALU_R] | cls[CL_ALU_I] | cls[CL_LDI])    s = T5;
    if (cls[CL_MULDIV] | cls[CL_BR])                    s = T6;
    if (cls[CL_LD] | cls[CL_ST])                        s = T7;
    return s;
  endfunction

endpackage

// File: rtl/control_unit_opcode_class_decode.sv
// Opcode -> one-hot instruction class and one-hot ALU operation; purely combinational.
// No flow control; undefined opcodes fall into the nop class.
module opcode_class_decode
  import control_unit_pkg::*;
(
  input  logic [OPW-1:0]  i_opcode,
  output logic [NCLS-1:0] o_cls,
  output logic [NALU-1:0] o_alu
);

  always_comb begin
    o_cls = '0;
    o_alu = '0;
    case (i_opcode)
      OP_ADD:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_ADD]  = 1'b1; end
      OP_SUB:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_SUB]  = 1'b1; end
      OP_AND:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_AND]  = 1'b1; end
      OP_OR:   begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_OR]   = 1'b1; end
      OP_ROR:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_ROR]  = 1'b1; end
      OP_ROL:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_ROL]  = 1'b1; end
      OP_SHR:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_SHR]  = 1'b1; end
      OP_SHRA: begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_SHRA] = 1'b1; end
      OP_SHL:  begin o_cls[CL_ALU_R]  = 1'b1; o_alu[A_SHL]  = 1'b1; end
      OP_ADDI: begin o_cls[CL_ALU_I]  = 1'b1; o_alu[A_ADD]  = 1'b1; end
      OP_ANDI: begin o_cls[CL_ALU_I]  = 1'b1; o_alu[A_AND]  = 1'b1; end
      OP_ORI:  begin o_cls[CL_ALU_I]  = 1'b1; o_alu[A_OR]   = 1'b1; end
      OP_MUL:  begin o_cls[CL_MULDIV] = 1'b1; o_alu[A_MUL]  = 1'b1; end
      OP_DIV:  begin o_cls[CL_MULDIV] = 1'b1; o_alu[A_DIV]  = 1'b1; end
      OP_NEG:  begin o_cls[CL_UNARY]  = 1'b1; o_alu[A_NEG]  = 1'b1; end
      OP_NOT:  begin o_cls[CL_UNARY]  = 1'b1; o_alu[A_NOT]  = 1'b1; end
      OP_LD:   o_cls[CL_LD]   = 1'b1;
      OP_LDI:  o_cls[CL_LDI]  = 1'b1;
      OP_ST:   o_cls[CL_ST]   = 1'b1;
      OP_BR:   o_cls[CL_BR]   = 1'b1;
      OP_JR:   o_cls[CL_JR]   = 1'b1;
      OP_JAL:  o_cls[CL_JAL]  = 1'b1;
      OP_IN:   o_cls[CL_IO]   = 1'b1;
      OP_OUT:  o_cls[CL_IO]   = 1'b1;
      OP_MFHI: o_cls[CL_MFX]  = 1'b1;
      OP_MFLO: o_cls[CL_MFX]  = 1'b1;
      OP_HALT: o_cls[CL_HALT] = 1'b1;
      default: o_cls[CL_NOP]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer; strobes are a combinational decode of the step register and IR opcode.
// One step per clock, no backpressure; stop is honoured only at an instruction boundary.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        run,
  output logic        CON_RESET,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        CONin,
  output logic        OUT_Portin,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT
);

  step_e           r_state;
  step_e           w_next;
  step_e           w_last;
  ctl_t            w_ctl;
  logic [OPW-1:0]  w_op;
  logic [NCLS-1:0] w_cls;
  logic [NALU-1:0] w_alu;
  logic            w_unused_ir;

  assign w_op        = IR[OP_HI:OP_LO];
  assign w_unused_ir = ^{IR[RA_HI:RA_LO], IR[RB_HI:RB_LO], IR[RC_HI:RC_LO], IR[C_HI:C_LO]};
  assign w_last      = last_step(w_cls);

  opcode_class_decode u_decode (
    .i_opcode (w_op),
    .o_cls    (w_cls),
    .o_alu    (w_alu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RST_S;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RST_S:          w_next = T0;
      HALT_S:         w_next = HALT_S;
      T0:             w_next = T1;
      T1:             w_next = T2;
      T2, T3, T4, T5, T6: w_next = step_e'(r_state + 4'd1);
      default:        w_next = T0;
    endcase
    // IR holds the new opcode during T2, so class-dependent exits are valid from T2 on.
    if (r_state == T2 && w_cls[CL_HALT]) begin
      w_next = HALT_S;
    end else if (r_state != T0 && r_state != T1 && r_state != RST_S &&
                 r_state != HALT_S && r_state == w_last) begin
      w_next = stop ? HALT_S : T0;
    end
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      RST_S: w_ctl.CON_RESET = 1'b1;
      T0: begin
        w_ctl.run = 1'b1; w_ctl.PCout = 1'b1; w_ctl.MARin = 1'b1;
        w_ctl.IncPC = 1'b1; w_ctl.Zin = 1'b1;
      end
      T1: begin
        w_ctl.run = 1'b1; w_ctl.Zlowout = 1'b1; w_ctl.PCin = 1'b1;
        w_ctl.Read = 1'b1; w_ctl.MDRin = 1'b1;
      end
      T2: begin
        w_ctl.run = 1'b1; w_ctl.MDRout = 1'b1; w_ctl.IRin = 1'b1;
      end
      T3, T4, T5, T6, T7: begin
        w_ctl.run = 1'b1;
        if (w_cls[CL_ALU_R] | w_cls[CL_ALU_I]) begin
          case (r_state)
            T3: begin w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.Yin = 1'b1; end
            T4: begin
              if (w_cls[CL_ALU_I]) w_ctl.Cout = 1'b1;
              else begin w_ctl.Grc = 1'b1; w_ctl.Rout = 1'b1; end
              w_ctl.alu = w_alu; w_ctl.Zin = 1'b1;
            end
            T5: begin w_ctl.Zlowout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
            default: ;
          endcase
        end
        if (w_cls[CL_MULDIV]) begin
          case (r_state)
            T3: begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.Yin = 1'b1; end
            T4: begin w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.alu = w_alu; w_ctl.Zin = 1'b1; end
            T5: begin w_ctl.Zlowout = 1'b1; w_ctl.LOin = 1'b1; end
            T6: begin w_ctl.Zhighout = 1'b1; w_ctl.HIin = 1'b1; end
            default: ;
          endcase
        end
        if (w_cls[CL_UNARY]) begin
          case (r_state)
            T3: begin w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.alu = w_alu; w_ctl.Zin = 1'b1; end
            T4: begin w_ctl.Zlowout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
            default: ;
          endcase
        end
        // ld, ldi and st share the base+offset address computation in T3-T4.
        if (w_cls[CL_LD] | w_cls[CL_LDI] | w_cls[CL_ST]) begin
          case (r_state)
            T3: begin w_ctl.Grb = 1'b1; w_ctl.BAout = 1'b1; w_ctl.Yin = 1'b1; end
            T4: begin w_ctl.Cout = 1'b1; w_ctl.alu[A_ADD] = 1'b1; w_ctl.Zin = 1'b1; end
            T5: begin
              w_ctl.Zlowout = 1'b1;
              if (w_cls[CL_LDI]) begin w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
              else               w_ctl.MARin = 1'b1;
            end
            T6: begin
              w_ctl.MDRin = 1'b1;
              if (w_cls[CL_ST]) begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; end
              else              w_ctl.Read = 1'b1;
            end
            T7: begin
              if (w_cls[CL_ST]) w_ctl.Write = 1'b1;
              else begin w_ctl.MDRout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1; end
            end
            default: ;
          endcase
        end
        if (w_cls[CL_BR]) begin
          case (r_state)
            T3: begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.CONin = 1'b1; end
            T4: begin w_ctl.PCout = 1'b1; w_ctl.Yin = 1'b1; end
            T5: begin w_ctl.Cout = 1'b1; w_ctl.alu[A_ADD] = 1'b1; w_ctl.Zin = 1'b1; end
            T6: begin w_ctl.Zlowout = CON_FF; w_ctl.PCin = CON_FF; end
            default: ;
          endcase
        end
        if (w_cls[CL_JR] && r_state == T3) begin
          w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.PCin = 1'b1;
        end
        if (w_cls[CL_JAL]) begin
          case (r_state)
            T3: begin w_ctl.PCout = 1'b1; w_ctl.Grb = 1'b1; w_ctl.Rin = 1'b1; end
            T4: begin w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.PCin = 1'b1; end
            default: ;
          endcase
        end
        if (w_cls[CL_IO] && r_state == T3) begin
          w_ctl.Gra = 1'b1;
          if (w_op == OP_IN) begin w_ctl.INout = 1'b1; w_ctl.Rin = 1'b1; end
          else begin w_ctl.Rout = 1'b1; w_ctl.OUT_Portin = 1'b1; end
        end
        if (w_cls[CL_MFX] && r_state == T3) begin
          w_ctl.HIout = (w_op == OP_MFHI);
          w_ctl.LOout = (w_op == OP_MFLO);
          w_ctl.Gra   = 1'b1;
          w_ctl.Rin   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run        = w_ctl.run;
  assign CON_RESET  = w_ctl.CON_RESET;
  assign HIout      = w_ctl.HIout;
  assign LOout      = w_ctl.LOout;
  assign Zhighout   = w_ctl.Zhighout;
  assign Zlowout    = w_ctl.Zlowout;
  assign PCout      = w_ctl.PCout;
  assign MDRout     = w_ctl.MDRout;
  assign INout      = w_ctl.INout;
  assign Cout       = w_ctl.Cout;
  assign Gra        = w_ctl.Gra;
  assign Grb        = w_ctl.Grb;
  assign Grc        = w_ctl.Grc;
  assign Rin        = w_ctl.Rin;
  assign Rout       = w_ctl.Rout;
  assign BAout      = w_ctl.BAout;
  assign HIin       = w_ctl.HIin;
  assign LOin       = w_ctl.LOin;
  assign PCin       = w_ctl.PCin;
  assign IRin       = w_ctl.IRin;
  assign Zin        = w_ctl.Zin;
  assign Yin        = w_ctl.Yin;
  assign MARin      = w_ctl.MARin;
  assign MDRin      = w_ctl.MDRin;
  assign CONin      = w_ctl.CONin;
  assign OUT_Portin = w_ctl.OUT_Portin;
  assign Read       = w_ctl.Read;
  assign Write      = w_ctl.Write;
  assign IncPC      = w_ctl.IncPC;
  assign AND        = w_ctl.alu[A_AND];
  assign OR         = w_ctl.alu[A_OR];
  assign ADD        = w_ctl.alu[A_ADD];
  assign SUB        = w_ctl.alu[A_SUB];
  assign MUL        = w_ctl.alu[A_MUL];
  assign DIV        = w_ctl.alu[A_DIV];
  assign SHR        = w_ctl.alu[A_SHR];
  assign SHRA       = w_ctl.alu[A_SHRA];
  assign SHL        = w_ctl.alu[A_SHL];
  assign ROR        = w_ctl.alu[A_ROR];
  assign ROL        = w_ctl.alu[A_ROL];
  assign NEG        = w_ctl.alu[A_NEG];
  assign NOT        = w_ctl.alu[A_NOT];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle expected strobe vectors queued by the driver, compared at negedge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset, stop, CON_FF;
  logic [31:0] IR;
  logic run, CON_RESET, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic Read, Write, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;

  control_unit dut (
    .clk(clk), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF),
    .run(run), .CON_RESET(CON_RESET), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .INout(INout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .HIin(HIin), .LOin(LOin), .PCin(PCin),
    .IRin(IRin), .Zin(Zin), .Yin(Yin), .MARin(MARin), .MDRin(MDRin),
    .CONin(CONin), .OUT_Portin(OUT_Portin), .Read(Read), .Write(Write),
    .IncPC(IncPC), .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL),
    .DIV(DIV), .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT)
  );

  always #5 clk = ~clk;

  localparam logic [41:0] M_RUN  = 42'd1 << 0,  M_CR    = 42'd1 << 1,  M_HIOUT = 42'd1 << 2;
  localparam logic [41:0] M_LOOUT = 42'd1 << 3, M_ZHI   = 42'd1 << 4,  M_ZLO   = 42'd1 << 5;
  localparam logic [41:0] M_PCOUT = 42'd1 << 6, M_MDROUT = 42'd1 << 7, M_INOUT = 42'd1 << 8;
  localparam logic [41:0] M_COUT = 42'd1 << 9,  M_GRA   = 42'd1 << 10, M_GRB   = 42'd1 << 11;
  localparam logic [41:0] M_GRC  = 42'd1 << 12, M_RIN   = 42'd1 << 13, M_ROUT  = 42'd1 << 14;
  localparam logic [41:0] M_BAOUT = 42'd1 << 15, M_HIIN = 42'd1 << 16, M_LOIN  = 42'd1 << 17;
  localparam logic [41:0] M_PCIN = 42'd1 << 18, M_IRIN  = 42'd1 << 19, M_ZIN   = 42'd1 << 20;
  localparam logic [41:0] M_YIN  = 42'd1 << 21, M_MARIN = 42'd1 << 22, M_MDRIN = 42'd1 << 23;
  localparam logic [41:0] M_CONIN = 42'd1 << 24, M_OUTP = 42'd1 << 25, M_READ  = 42'd1 << 26;
  localparam logic [41:0] M_WRITE = 42'd1 << 27, M_INCPC = 42'd1 << 28, M_AND  = 42'd1 << 29;
  localparam logic [41:0] M_OR   = 42'd1 << 30, M_ADD   = 42'd1 << 31, M_SUB   = 42'd1 << 32;
  localparam logic [41:0] M_MUL  = 42'd1 << 33, M_NEG   = 42'd1 << 40;

  localparam logic [41:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [41:0] F1 = M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [41:0] F2 = M_RUN | M_MDROUT | M_IRIN;

  logic [41:0] w_obs;
  assign w_obs = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND,
                  IncPC, Write, Read, OUT_Portin, CONin, MDRin, MARin, Yin, Zin, IRin,
                  PCin, LOin, HIin, BAout, Rout, Rin, Grc, Grb, Gra, Cout, INout,
                  MDRout, PCout, Zlowout, Zhighout, LOout, HIout, CON_RESET, run};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [41:0] sb_q[$];
  string       tag_q[$];
  logic [41:0] mon_exp;
  string       mon_tag;

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, w_obs, mon_exp);
    end
  end

  // Inputs for this cycle are already applied; queue what the DUT must show, then advance.
  task automatic step(input string tag, input logic [41:0] e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string tag, input logic [41:0] e);
    step(tag, M_RUN | e);
  endtask

  task automatic fetch(input logic [31:0] ir);
    step("fetch_t0", F0);
    step("fetch_t1", F1);
    IR = ir;
    step("fetch_t2", F2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("rst_hold", M_CR);
    reset = 1'b0;
    step("rst_rel", M_CR);
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; CON_FF = 1'b0; IR = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    fetch(32'h19890000);
    ex("add_t3", M_GRB | M_ROUT | M_YIN);
    ex("add_t4", M_GRC | M_ROUT | M_ADD | M_ZIN);
    ex("add_t5", M_ZLO | M_GRA | M_RIN);

    fetch(32'h00800005);
    ex("ld_t3", M_GRB | M_BAOUT | M_YIN);
    ex("ld_t4", M_COUT | M_ADD | M_ZIN);
    ex("ld_t5", M_ZLO | M_MARIN);
    ex("ld_t6", M_READ | M_MDRIN);
    ex("ld_t7", M_MDROUT | M_GRA | M_RIN);

    for (int c = 0; c < 2; c++) begin
      CON_FF = c[0];
      fetch(32'h98000000);
      ex("br_t3", M_GRA | M_ROUT | M_CONIN);
      ex("br_t4", M_PCOUT | M_YIN);
      ex("br_t5", M_COUT | M_ADD | M_ZIN);
      ex("br_t6", c[0] ? (M_ZLO | M_PCIN) : '0);
    end
    CON_FF = 1'b0;

    fetch(32'h60000000);
    ex("addi_t3", M_GRB | M_ROUT | M_YIN);
    ex("addi_t4", M_COUT | M_ADD | M_ZIN);
    ex("addi_t5", M_ZLO | M_GRA | M_RIN);

    fetch(32'h88000000);
    ex("neg_t3", M_GRB | M_ROUT | M_NEG | M_ZIN);
    ex("neg_t4", M_ZLO | M_GRA | M_RIN);

    fetch(32'h10000000);
    ex("st_t3", M_GRB | M_BAOUT | M_YIN);
    ex("st_t4", M_COUT | M_ADD | M_ZIN);
    ex("st_t5", M_ZLO | M_MARIN);
    ex("st_t6", M_GRA | M_ROUT | M_MDRIN);
    ex("st_t7", M_WRITE);

    fetch(32'hA8000000);
    ex("jal_t3", M_PCOUT | M_GRB | M_RIN);
    ex("jal_t4", M_GRA | M_ROUT | M_PCIN);

    fetch(32'hB8000000);
    ex("out_t3", M_GRA | M_ROUT | M_OUTP);

    fetch(32'hC8000000);
    ex("mflo_t3", M_LOOUT | M_GRA | M_RIN);

    fetch(32'h78000000);
    ex("mul_t3", M_GRA | M_ROUT | M_YIN);
    ex("mul_t4", M_GRB | M_ROUT | M_MUL | M_ZIN);
    ex("mul_t5", M_ZLO | M_LOIN);
    ex("mul_t6", M_ZHI | M_HIIN);

    fetch(32'h78000000);
    ex("mul2_t3", M_GRA | M_ROUT | M_YIN);
    reset = 1'b1;
    step("mul_rst_t4", M_CR);
    reset = 1'b0;
    step("mul_rst_rel", M_CR);

    fetch(32'hD8000000);
    for (int i = 0; i < 20; i++) step("halted", '0);
    do_reset();

    fetch(32'h19890000);
    stop = 1'b1;
    ex("stop_add_t3", M_GRB | M_ROUT | M_YIN);
    ex("stop_add_t4", M_GRC | M_ROUT | M_ADD | M_ZIN);
    ex("stop_add_t5", M_ZLO | M_GRA | M_RIN);
    step("stop_halt", '0);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) step("stop_hold", '0);
    do_reset();

    fetch(32'hF8000000);
    fetch(32'hD0000000);
    fetch(32'hC0000000);
    ex("mfhi_t3", M_HIOUT | M_GRA | M_RIN);
    step("after_mfhi_t0", F0);

    @(negedge clk);
    #1;
    check("sb_drained", 42'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
